// File: rtl/vec_switch_port.sv
// Switch port for a vector core: a circular send FIFO that drains over the switch send
// handshake, plus a single-outstanding receive engine with an optional timeout.
module vec_switch_port #(
    parameter int SWITCH_WIDTH     = 16,
    parameter int ELEM_BITS        = 32,
    parameter int SWITCH_CORE_SIZE = 4,
    parameter int SEND_DEPTH       = 4,
    parameter int RECV_TIMEOUT     = 255,
    localparam int MSG_BITS        = SWITCH_WIDTH * ELEM_BITS,
    localparam int CORE_BITS       = $clog2(SWITCH_CORE_SIZE),
    localparam int CNT_BITS        = $clog2(SEND_DEPTH) + 1
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 send_valid,
    input  logic [CORE_BITS-1:0] send_core_idx,
    input  logic [MSG_BITS-1:0]  send_data,
    output logic                 send_accept,
    output logic [CNT_BITS-1:0]  send_count,
    input  logic                 recv_req,
    input  logic [CORE_BITS-1:0] recv_core_idx,
    output logic                 recv_busy,
    output logic                 recv_done,
    output logic                 recv_timeout,
    output logic [MSG_BITS-1:0]  recv_data,
    output logic                 idle,
    output logic                 switch_send_ready,
    output logic [CORE_BITS-1:0] switch_send_core_idx,
    output logic [MSG_BITS-1:0]  switch_send_data,
    input  logic                 switch_send_ok,
    output logic                 switch_recv_request,
    output logic [CORE_BITS-1:0] switch_recv_core_idx,
    input  logic                 switch_recv_ready,
    input  logic [MSG_BITS-1:0]  switch_recv_data,
    output logic [1:0]           recv_state_dbg
);
    localparam int PTR_BITS   = $clog2(SEND_DEPTH);
    localparam int TIMER_BITS = (RECV_TIMEOUT > 1) ? $clog2(RECV_TIMEOUT) : 1;

    // Handshakes: a transfer happens on a rising edge where the offering side's valid
    // (send_valid / switch_send_ready) and the taking side's ready (send_accept /
    // switch_send_ok) are both high; valid never depends on ready in the same cycle.
    logic [CORE_BITS-1:0] idx_mem  [SEND_DEPTH];
    logic [MSG_BITS-1:0]  data_mem [SEND_DEPTH];
    logic [PTR_BITS-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_BITS-1:0]  count_q, count_d;
    logic                 push, pop;

    assign send_accept       = (count_q != CNT_BITS'(SEND_DEPTH));
    assign switch_send_ready = (count_q != '0);
    assign send_count        = count_q;
    assign push              = send_valid && send_accept;
    assign pop               = switch_send_ready && switch_send_ok;

    // Head is masked while empty so stale storage never reaches the switch.
    assign switch_send_core_idx = switch_send_ready ? idx_mem[rd_ptr_q]  : '0;
    assign switch_send_data     = switch_send_ready ? data_mem[rd_ptr_q] : '0;

    always_comb begin
        wr_ptr_d = push ? PTR_BITS'(wr_ptr_q + 1'b1) : wr_ptr_q;
        rd_ptr_d = pop  ? PTR_BITS'(rd_ptr_q + 1'b1) : rd_ptr_q;
        count_d  = count_q;
        if (push && !pop)      count_d = count_q + CNT_BITS'(1);
        else if (pop && !push) count_d = count_q - CNT_BITS'(1);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clock) begin
        if (push) begin
            idx_mem[wr_ptr_q]  <= send_core_idx;
            data_mem[wr_ptr_q] <= send_data;
        end
    end

    typedef enum logic [1:0] {RX_IDLE = 2'd0, RX_WAIT = 2'd1, RX_DONE = 2'd2} rx_state_e;

    rx_state_e             state_q, state_d;
    logic [TIMER_BITS-1:0] timer_q, timer_d;
    logic [CORE_BITS-1:0]  ridx_q, ridx_d;
    logic [MSG_BITS-1:0]   rdata_q, rdata_d;
    logic                  tmo_q, tmo_d;
    logic                  timeout_hit;

    // A zero RECV_TIMEOUT disables the limit; the timer then just free-runs.
    assign timeout_hit = (RECV_TIMEOUT != 0) && (timer_q == TIMER_BITS'(RECV_TIMEOUT - 1));

    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        ridx_d  = ridx_q;
        rdata_d = rdata_q;
        tmo_d   = 1'b0;
        case (state_q)
            RX_IDLE: begin
                if (recv_req) begin
                    ridx_d  = recv_core_idx;
                    timer_d = '0;
                    state_d = RX_WAIT;
                end
            end
            RX_WAIT: begin
                if (switch_recv_ready) begin
                    rdata_d = switch_recv_data;
                    state_d = RX_DONE;
                end else if (timeout_hit) begin
                    tmo_d   = 1'b1;
                    state_d = RX_IDLE;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            RX_DONE: state_d = RX_IDLE;
            default: state_d = RX_IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= RX_IDLE;
            timer_q <= '0;
            ridx_q  <= '0;
            rdata_q <= '0;
            tmo_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            ridx_q  <= ridx_d;
            rdata_q <= rdata_d;
            tmo_q   <= tmo_d;
        end
    end

    assign recv_busy            = (state_q != RX_IDLE);
    assign recv_done            = (state_q == RX_DONE);
    assign recv_timeout         = tmo_q;
    assign recv_data            = rdata_q;
    assign switch_recv_request  = (state_q == RX_WAIT);
    assign switch_recv_core_idx = (state_q == RX_WAIT) ? ridx_q : '0;
    assign idle                 = (count_q == '0) && (state_q == RX_IDLE);
    assign recv_state_dbg       = state_q;
endmodule

// File: tb/tb_vec_switch_port.sv
// Bench for vec_switch_port: a table of send-FIFO vectors, directed receive/reset
// sequences, and randomized traffic checked against a queue-based reference model.
module tb_vec_switch_port;
    localparam int SW = 16;
    localparam int EB = 32;
    localparam int MB = SW * EB;
    localparam int CB = 2;
    localparam int DEPTH = 4;
    localparam int TMO = 8;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          send_valid = 1'b0;
    logic [CB-1:0] send_core_idx = '0;
    logic [MB-1:0] send_data = '0;
    logic          send_accept;
    logic [2:0]    send_count;
    logic          recv_req = 1'b0;
    logic [CB-1:0] recv_core_idx = '0;
    logic          recv_busy, recv_done, recv_timeout, idle;
    logic [MB-1:0] recv_data;
    logic          switch_send_ready;
    logic [CB-1:0] switch_send_core_idx;
    logic [MB-1:0] switch_send_data;
    logic          switch_send_ok = 1'b0;
    logic          switch_recv_request;
    logic [CB-1:0] switch_recv_core_idx;
    logic          switch_recv_ready = 1'b0;
    logic [MB-1:0] switch_recv_data = '0;
    logic [1:0]    recv_state_dbg;

    int checks = 0;
    int errors = 0;

    vec_switch_port #(
        .SWITCH_WIDTH(SW), .ELEM_BITS(EB), .SWITCH_CORE_SIZE(4),
        .SEND_DEPTH(DEPTH), .RECV_TIMEOUT(TMO)
    ) dut (
        .clock(clock), .reset(reset),
        .send_valid(send_valid), .send_core_idx(send_core_idx), .send_data(send_data),
        .send_accept(send_accept), .send_count(send_count),
        .recv_req(recv_req), .recv_core_idx(recv_core_idx),
        .recv_busy(recv_busy), .recv_done(recv_done), .recv_timeout(recv_timeout),
        .recv_data(recv_data), .idle(idle),
        .switch_send_ready(switch_send_ready), .switch_send_core_idx(switch_send_core_idx),
        .switch_send_data(switch_send_data), .switch_send_ok(switch_send_ok),
        .switch_recv_request(switch_recv_request), .switch_recv_core_idx(switch_recv_core_idx),
        .switch_recv_ready(switch_recv_ready), .switch_recv_data(switch_recv_data),
        .recv_state_dbg(recv_state_dbg)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic        v;
        logic [1:0]  idx;
        logic [31:0] e0;
        logic        ok;
        int          exp_cnt;
        logic        exp_acc;
        logic        exp_rdy;
        logic [1:0]  exp_idx;
        logic [31:0] exp_e0;
    } vec_t;

    typedef struct {
        logic [CB-1:0] idx;
        logic [MB-1:0] data;
    } msg_t;

    vec_t tbl[$];
    msg_t model_q[$];
    logic [MB-1:0] exp_q[$];

    function automatic logic [MB-1:0] mk_msg(input logic [31:0] e0);
        logic [MB-1:0] m;
        for (int i = 0; i < SW; i++) m[i*EB +: EB] = e0 + 32'(i);
        return m;
    endfunction

    function automatic logic [MB-1:0] rand_msg();
        logic [MB-1:0] m;
        for (int i = 0; i < SW; i++) m[i*EB +: EB] = $urandom;
        return m;
    endfunction

    function automatic vec_t row(input logic v, input logic [1:0] idx, input logic [31:0] e0,
                                 input logic ok, input int cnt, input logic acc,
                                 input logic rdy, input logic [1:0] hidx, input logic [31:0] he0);
        vec_t r;
        r.v = v; r.idx = idx; r.e0 = e0; r.ok = ok;
        r.exp_cnt = cnt; r.exp_acc = acc; r.exp_rdy = rdy; r.exp_idx = hidx; r.exp_e0 = he0;
        return r;
    endfunction

    task automatic chk(input string name, input logic [MB-1:0] act, input logic [MB-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic cycle();
        @(posedge clock);
        #1;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, " send_count"}, MB'(send_count), MB'(0));
        chk({tag, " send_accept"}, MB'(send_accept), MB'(1));
        chk({tag, " send_ready"}, MB'(switch_send_ready), MB'(0));
        chk({tag, " recv_request"}, MB'(switch_recv_request), MB'(0));
        chk({tag, " recv_busy"}, MB'(recv_busy), MB'(0));
        chk({tag, " recv_done"}, MB'(recv_done), MB'(0));
        chk({tag, " recv_timeout"}, MB'(recv_timeout), MB'(0));
        chk({tag, " recv_data"}, recv_data, MB'(0));
        chk({tag, " idle"}, MB'(idle), MB'(1));
        chk({tag, " send_idx"}, MB'(switch_send_core_idx), MB'(0));
        chk({tag, " send_data"}, switch_send_data, MB'(0));
        chk({tag, " recv_idx"}, MB'(switch_recv_core_idx), MB'(0));
    endtask

    // Runs one request; the switch answers on WAIT cycle ready_at (values above TMO never answer).
    task automatic recv_trial(input string tag, input logic [1:0] core, input int ready_at,
                              input logic [MB-1:0] payload, inout logic [MB-1:0] last_rx);
        int wait_cycles;
        recv_req = 1'b1;
        recv_core_idx = core;
        cycle();
        recv_req = 1'b0;
        wait_cycles = 0;
        for (int w = 1; w <= TMO; w++) begin
            chk({tag, " request"}, MB'(switch_recv_request), MB'(1));
            chk({tag, " recv_idx"}, MB'(switch_recv_core_idx), MB'(core));
            chk({tag, " no_early_timeout"}, MB'(recv_timeout), MB'(0));
            wait_cycles++;
            switch_recv_ready = (w == ready_at);
            switch_recv_data = payload;
            cycle();
            if (w == ready_at) break;
        end
        switch_recv_ready = 1'b0;
        switch_recv_data = rand_msg();
        if (ready_at <= TMO) begin
            exp_q.push_back(payload);
            chk({tag, " wait_cycles"}, MB'(wait_cycles), MB'(ready_at));
            chk({tag, " done"}, MB'(recv_done), MB'(1));
            chk({tag, " timeout"}, MB'(recv_timeout), MB'(0));
            chk({tag, " request_low"}, MB'(switch_recv_request), MB'(0));
            chk({tag, " data"}, recv_data, exp_q.pop_front());
            last_rx = payload;
        end else begin
            chk({tag, " wait_cycles"}, MB'(wait_cycles), MB'(TMO));
            chk({tag, " timeout"}, MB'(recv_timeout), MB'(1));
            chk({tag, " done"}, MB'(recv_done), MB'(0));
            chk({tag, " busy"}, MB'(recv_busy), MB'(0));
            chk({tag, " data_held"}, recv_data, last_rx);
        end
        cycle();
        chk({tag, " done_cleared"}, MB'(recv_done), MB'(0));
        chk({tag, " timeout_cleared"}, MB'(recv_timeout), MB'(0));
        chk({tag, " busy_after"}, MB'(recv_busy), MB'(0));
        chk({tag, " data_after"}, recv_data, last_rx);
    endtask

    initial begin
        logic [MB-1:0] last_rx;
        logic [MB-1:0] pat;
        last_rx = '0;

        // Test 1: three ordered sends.
        tbl.push_back(row(1, 1, 32'h3F800000, 0, 1, 1, 1, 1, 32'h3F800000));
        tbl.push_back(row(1, 2, 32'h40000000, 0, 2, 1, 1, 1, 32'h3F800000));
        tbl.push_back(row(1, 3, 32'h40400000, 0, 3, 1, 1, 1, 32'h3F800000));
        tbl.push_back(row(0, 0, 32'h0, 1, 2, 1, 1, 2, 32'h40000000));
        tbl.push_back(row(0, 0, 32'h0, 1, 1, 1, 1, 3, 32'h40400000));
        tbl.push_back(row(0, 0, 32'h0, 1, 0, 1, 0, 0, 32'h0));
        // Test 2: fill, drop when full, full refuses push even with a pop.
        tbl.push_back(row(1, 0, 32'h10, 0, 1, 1, 1, 0, 32'h10));
        tbl.push_back(row(1, 1, 32'h11, 0, 2, 1, 1, 0, 32'h10));
        tbl.push_back(row(1, 2, 32'h12, 0, 3, 1, 1, 0, 32'h10));
        tbl.push_back(row(1, 3, 32'h13, 0, 4, 0, 1, 0, 32'h10));
        tbl.push_back(row(1, 1, 32'h14, 0, 4, 0, 1, 0, 32'h10));
        tbl.push_back(row(1, 2, 32'h15, 1, 3, 1, 1, 1, 32'h11));
        tbl.push_back(row(1, 2, 32'h16, 1, 3, 1, 1, 2, 32'h12));
        tbl.push_back(row(0, 0, 32'h0, 1, 2, 1, 1, 3, 32'h13));
        tbl.push_back(row(0, 0, 32'h0, 1, 1, 1, 1, 2, 32'h16));
        tbl.push_back(row(0, 0, 32'h0, 1, 0, 1, 0, 0, 32'h0));
        tbl.push_back(row(0, 0, 32'h0, 1, 0, 1, 0, 0, 32'h0));
        // Test 3: streaming with ok held high keeps exactly one entry in flight.
        for (int i = 0; i < 6; i++)
            tbl.push_back(row(1, 2'(i), 32'h20 + 32'(i), 1, 1, 1, 1, 2'(i), 32'h20 + 32'(i)));
        tbl.push_back(row(0, 0, 32'h0, 1, 0, 1, 0, 0, 32'h0));

        #1;
        chk_reset_outputs("in_reset");
        cycle();
        reset = 1'b0;
        cycle();
        chk_reset_outputs("after_reset");

        foreach (tbl[i]) begin
            send_valid = tbl[i].v;
            send_core_idx = tbl[i].idx;
            send_data = mk_msg(tbl[i].e0);
            switch_send_ok = tbl[i].ok;
            cycle();
            chk($sformatf("vec%0d count", i), MB'(send_count), MB'(tbl[i].exp_cnt));
            chk($sformatf("vec%0d accept", i), MB'(send_accept), MB'(tbl[i].exp_acc));
            chk($sformatf("vec%0d ready", i), MB'(switch_send_ready), MB'(tbl[i].exp_rdy));
            chk($sformatf("vec%0d head_idx", i), MB'(switch_send_core_idx), MB'(tbl[i].exp_idx));
            chk($sformatf("vec%0d head_data", i), switch_send_data,
                tbl[i].exp_rdy ? mk_msg(tbl[i].exp_e0) : MB'(0));
            chk($sformatf("vec%0d idle", i), MB'(idle), MB'(tbl[i].exp_cnt == 0));
        end
        send_valid = 1'b0;
        switch_send_ok = 1'b0;

        // Randomized send traffic against a queue model.
        for (int c = 0; c < 300; c++) begin
            bit do_push, do_pop;
            msg_t m;
            send_valid = 1'($urandom_range(0, 1));
            send_core_idx = CB'($urandom_range(0, 3));
            send_data = rand_msg();
            switch_send_ok = ($urandom_range(0, 99) < 45);
            do_push = send_valid && (model_q.size() < DEPTH);
            do_pop = switch_send_ok && (model_q.size() > 0);
            m.idx = send_core_idx;
            m.data = send_data;
            cycle();
            if (do_pop) void'(model_q.pop_front());
            if (do_push) model_q.push_back(m);
            chk("rnd count", MB'(send_count), MB'(model_q.size()));
            chk("rnd accept", MB'(send_accept), MB'(model_q.size() < DEPTH));
            chk("rnd ready", MB'(switch_send_ready), MB'(model_q.size() > 0));
            chk("rnd idle", MB'(idle), MB'(model_q.size() == 0));
            if (model_q.size() > 0) begin
                chk("rnd head_idx", MB'(switch_send_core_idx), MB'(model_q[0].idx));
                chk("rnd head_data", switch_send_data, model_q[0].data);
            end
        end
        send_valid = 1'b0;
        switch_send_ok = 1'b1;
        for (int c = 0; c < DEPTH + 1; c++) cycle();
        switch_send_ok = 1'b0;
        model_q.delete();
        chk("drained idle", MB'(idle), MB'(1));

        // Test 4: answer on the 5th WAIT cycle.
        for (int i = 0; i < SW; i++) pat[i*EB +: EB] = 32'hA5A5_0000 + 32'(i);
        recv_trial("rx5", 2'd2, 5, pat, last_rx);
        // Test 5: timeout after 8 WAIT cycles, then answer exactly on the 8th.
        recv_trial("rx_tmo", 2'd1, TMO + 1, rand_msg(), last_rx);
        recv_trial("rx8", 2'd3, TMO, rand_msg(), last_rx);
        for (int t = 0; t < 8; t++)
            recv_trial($sformatf("rx_rnd%0d", t), CB'($urandom_range(0, 3)),
                       $urandom_range(1, TMO + 2), rand_msg(), last_rx);

        // Test 6: asynchronous reset mid-WAIT with two queued messages.
        send_valid = 1'b1;
        for (int i = 0; i < 2; i++) begin
            send_core_idx = CB'(i + 1);
            send_data = rand_msg();
            cycle();
        end
        send_valid = 1'b0;
        recv_req = 1'b1;
        recv_core_idx = 2'd2;
        cycle();
        recv_req = 1'b0;
        cycle();
        chk("pre_reset count", MB'(send_count), MB'(2));
        chk("pre_reset request", MB'(switch_recv_request), MB'(1));
        #2;
        reset = 1'b1;
        #1;
        chk_reset_outputs("async_reset");
        cycle();
        #3;
        reset = 1'b0;
        switch_send_ok = 1'b1;
        for (int c = 0; c < 3; c++) begin
            cycle();
            chk("post_reset ready", MB'(switch_send_ready), MB'(0));
            chk("post_reset count", MB'(send_count), MB'(0));
            chk("post_reset idle", MB'(idle), MB'(1));
            chk("post_reset send_data", switch_send_data, MB'(0));
        end
        switch_send_ok = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/vec_switch_port.md
Name: vec_switch_port

Overview:
Buffered, parametrised interface between a vector core's control and the inter-core switch.
- Send side: queues outgoing vector messages in a SEND_DEPTH-entry FIFO and drains them over the switch send handshake.
- Receive side: single-outstanding request engine with optional timeout.
- Decouples control from switch back-pressure so compute can keep issuing while sends are pending.

Parameters:
SWITCH_WIDTH, 16, elements per switch message
ELEM_BITS, 32, bits per element (raw IEEE-754 single bit pattern)
SWITCH_CORE_SIZE, 4, number of addressable cores; CORE_BITS = $clog2(SWITCH_CORE_SIZE)
SEND_DEPTH, 4, send FIFO entries (power of two, >=2)
RECV_TIMEOUT, 255, cycles to wait for switch_recv_ready; 0 = never time out
MSG_BITS, SWITCH_WIDTH*ELEM_BITS, derived, packed message width

Ports:
clock  in  1  single clock, rising edge
reset  in  1  asynchronous, active-high
send_valid  in  1  control offers a message
send_core_idx  in  CORE_BITS  destination core
send_data  in  MSG_BITS  message payload, element i at [i*ELEM_BITS +: ELEM_BITS]
send_accept  out  1  FIFO not full (combinational from state)
send_count  out  $clog2(SEND_DEPTH)+1  current FIFO occupancy
recv_req  in  1  request one message
recv_core_idx  in  CORE_BITS  source core
recv_busy  out  1  receive engine not IDLE
recv_done  out  1  one-cycle pulse, recv_data valid
recv_timeout  out  1  one-cycle pulse, request abandoned
recv_data  out  MSG_BITS  last received message (held)
idle  out  1  FIFO empty and receive engine IDLE
switch_send_ready  out  1  head message presented
switch_send_core_idx  out  CORE_BITS  head destination
switch_send_data  out  MSG_BITS  head payload
switch_send_ok  in  1  switch accepts head this cycle
switch_recv_request  out  1  receive request active
switch_recv_core_idx  out  CORE_BITS  requested source
switch_recv_ready  in  1  switch data valid this cycle
switch_recv_data  in  MSG_BITS  incoming payload

Behaviour:
- Reset (async, immediate) clears all state. Output values during and after reset:
  - send_count=0, send_accept=1
  - switch_send_ready=0, switch_recv_request=0
  - recv_busy=0, recv_done=0, recv_timeout=0
  - recv_data=0, idle=1
  - core_idx/data outputs=0
  - Reset mid-transfer drops all queued messages and any pending receive.
- Send FIFO: circular buffer, read/write pointers of $clog2(SEND_DEPTH) bits wrap modulo SEND_DEPTH.
  - Push: at a rising edge with send_valid && send_accept.
  - send_accept = (send_count != SEND_DEPTH). A full FIFO refuses a push even if a pop occurs the same cycle.
  - switch_send_ready = (send_count != 0). switch_send_core_idx/data show the head entry, driven from registered storage.
  - Pop: at an edge with switch_send_ready && switch_send_ok. switch_send_ok while not ready is ignored.
  - Simultaneous push and pop with 0 < count < DEPTH: count unchanged, both pointers advance.
  - Push into empty FIFO: switch_send_ready=1 the next cycle (1-cycle latency). Back-to-back pops at one message/cycle when ok is held high.
  - Messages leave in enqueue order. Payload and index are never altered.
- Receive FSM states: IDLE, WAIT, DONE.
  - IDLE: on recv_req, latch recv_core_idx, clear timer, go to WAIT. recv_req in any other state is ignored.
  - WAIT: switch_recv_request=1, switch_recv_core_idx=latched index.
    - If switch_recv_ready: capture switch_recv_data into recv_data, go to DONE.
    - Else if RECV_TIMEOUT!=0 and timer==RECV_TIMEOUT-1: go to IDLE and pulse recv_timeout for one cycle (registered). recv_data is unchanged.
    - Else timer+1.
    - If ready and timeout coincide, ready wins.
  - DONE: recv_done=1 for exactly one cycle, switch_recv_request=0, then IDLE.
  - Minimum receive latency: recv_req edge to recv_done = 2 cycles when ready is already high.
  - recv_busy = (state != IDLE).
- Send and receive paths are independent and may be active concurrently.
- idle = (send_count==0) && (state==IDLE).

Test Plan:
1. Reset, then push 3 messages (dest 1,2,3; element0 = 0x3F800000, 0x40000000, 0x40400000) with switch_send_ok=0 -> send_count=3, switch_send_ready=1, head dest=1. Raise ok for 3 cycles -> dests 1,2,3 delivered in order, send_count=0, idle=1.
2. Fill FIFO to 4 with ok=0 -> send_accept=0 and a 5th push is dropped. Assert ok and send_valid in the same cycle -> count goes to 3 and the 5th message is still not stored that cycle. Drive 10 further pushes/pops -> pointers wrap, order preserved.
3. Hold ok=1 while streaming push every cycle -> count stays at 1 after the first cycle, one message delivered per cycle.
4. recv_req core 2, switch_recv_ready asserted on the 5th WAIT cycle with pattern 0xA5A5_0000+i per element -> switch_recv_request high 5 cycles, recv_done pulse one cycle, recv_data matches and is held afterwards.
5. RECV_TIMEOUT=8, recv_req with ready never asserted -> recv_timeout pulses after 8 WAIT cycles, recv_busy=0, recv_data unchanged. Repeat with ready on the 8th cycle -> recv_done fires, no timeout pulse.
6. Assert reset asynchronously mid-WAIT with 2 queued messages -> outputs reach reset values immediately, without waiting for a clock edge. After release, idle=1 and no stale message appears on the switch.
